rob_multi_commit: RTL and testbench

Parametrised reorder buffer for the out-of-order core, sitting between the decoder/dispatch stage and the register file, reservation stations and load/store buffer. Holds up to DEPTH in-flight instructions in a circular queue, accepts results from two CDB write-back ports, and answers two operand lookups per cycle. Retires up to COMMIT_W instructions per cycle in order, hands committed stores to the LSB through a request/acknowledge pair, and raises a flush with a redirect PC on branch mispredict or JALR.

---
 rtl/rob_multi_commit.sv | 210 +++++++++++++++++++++
 tb/tb_rob_multi_commit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi_commit.sv
// rob_multi_commit
//   Reorder buffer between dispatch and the register file / RS / LSB.
//   DEPTH entries in a circular queue. Two CDB write-back ports, two operand
//   lookups, and in-order retirement of up to COMMIT_W entries per cycle.
//   Committed stores go to the LSB through a req/ack pair. A mispredicted
//   BRANCH or any JALR at the head raises a flush with a redirect PC.
//
//   Optional feature macro: ROB_CDB_BYPASS_EN
//     When defined, a lookup that matches a same-cycle CDB write-back
//     returns that value as ready (wb1 wins over wb0). Commit is unaffected.
//
// Ports
//   clk_in, rst_n_in (async, active low), rdy_in (global pause)
//   disp_*        : dispatch handshake, entry payload and allocated tag
//   rd0_*, rd1_*  : operand lookup by tag
//   wb0_*         : ALU CDB (value, branch taken, JALR target)
//   wb1_*         : load/store CDB (value)
//   cm_*          : per-slot retire valid / rd / value / tag
//   st_commit_*   : store retire handshake with the LSB
//   flush_*       : pipeline redirect
//   count_out     : occupied entries
module rob_multi_commit #(
  parameter int DEPTH    = 32,
  parameter int TAG_W    = 5,
  parameter int COMMIT_W = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      disp_valid_in,
  output logic                      disp_ready_out,
  input  logic [2:0]                disp_type_in,
  input  logic [4:0]                disp_rd_in,
  input  logic [31:0]               disp_alt_pc_in,
  input  logic                      disp_pred_taken_in,
  input  logic                      disp_done_in,
  input  logic [31:0]               disp_value_in,
  output logic [TAG_W-1:0]          disp_tag_out,
  input  logic [TAG_W-1:0]          rd0_tag_in,
  input  logic [TAG_W-1:0]          rd1_tag_in,
  output logic                      rd0_ready_out,
  output logic                      rd1_ready_out,
  output logic [31:0]               rd0_value_out,
  output logic [31:0]               rd1_value_out,
  input  logic                      wb0_valid_in,
  input  logic [TAG_W-1:0]          wb0_tag_in,
  input  logic [31:0]               wb0_value_in,
  input  logic                      wb0_taken_in,
  input  logic [31:0]               wb0_target_in,
  input  logic                      wb1_valid_in,
  input  logic [TAG_W-1:0]          wb1_tag_in,
  input  logic [31:0]               wb1_value_in,
  output logic [COMMIT_W-1:0]       cm_valid_out,
  output logic [5*COMMIT_W-1:0]     cm_rd_out,
  output logic [32*COMMIT_W-1:0]    cm_value_out,
  output logic [TAG_W*COMMIT_W-1:0] cm_tag_out,
  output logic                      st_commit_req_out,
  input  logic                      st_commit_ack_in,
  output logic                      flush_out,
  output logic [31:0]               flush_pc_out,
  output logic [TAG_W:0]            count_out
);

  localparam logic [2:0]     T_ALU    = 3'd0;
  localparam logic [2:0]     T_LOAD   = 3'd1;
  localparam logic [2:0]     T_STORE  = 3'd2;
  localparam logic [2:0]     T_BRANCH = 3'd3;
  localparam logic [2:0]     T_JALR   = 3'd4;
  localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(DEPTH);

  // control state (reset)
  logic [DEPTH-1:0] vld_q, done_q;
  logic [TAG_W-1:0] head_q, tail_q;
  logic [TAG_W:0]   count_q;

  // payload (no reset; only meaningful while vld_q is set)
  logic [DEPTH-1:0] pred_q, taken_q;
  logic [2:0]       type_q  [DEPTH];
  logic [4:0]       rd_q    [DEPTH];
  logic [31:0]      value_q [DEPTH];
  logic [31:0]      pc_q    [DEPTH];  // BRANCH: alt_pc, JALR: resolved target

  logic [TAG_W-1:0] h0, h1;
  logic             head_ok, simple0, simple1;
  logic [1:0]       ret, n_ret;
  logic             disp_fire, wb0_hit, wb1_hit;
  logic [DEPTH-1:0] vld_d, done_d;

  // ---------------- commit ----------------
  assign h0 = head_q;
  assign h1 = head_q + TAG_W'(1);

  assign head_ok = rdy_in & vld_q[h0] & done_q[h0];
  assign simple0 = (type_q[h0] == T_ALU) | (type_q[h0] == T_LOAD);
  assign simple1 = (type_q[h1] == T_ALU) | (type_q[h1] == T_LOAD);

  assign st_commit_req_out = head_ok & (type_q[h0] == T_STORE);
  assign flush_out = head_ok &
                     (((type_q[h0] == T_BRANCH) & (taken_q[h0] != pred_q[h0])) |
                      (type_q[h0] == T_JALR));
  assign flush_pc_out = pc_q[h0];

  // a redirecting entry still retires so its link rd reaches the RF
  assign ret[0] = head_ok & ((type_q[h0] != T_STORE) | st_commit_ack_in);
  // second slot only pairs plain ALU/LOAD ops, so it never follows a flush
  assign ret[1] = (COMMIT_W == 2) & ret[0] & simple0 & simple1 &
                  vld_q[h1] & done_q[h1];
  assign n_ret  = {1'b0, ret[0]} + {1'b0, ret[1]};

  assign cm_valid_out = ret[COMMIT_W-1:0];

  for (genvar s = 0; s < COMMIT_W; s++) begin : g_slot
    logic [TAG_W-1:0] idx;
    assign idx = head_q + TAG_W'(s);
    assign cm_rd_out[5*s +: 5]             = rd_q[idx];
    assign cm_value_out[32*s +: 32]        = value_q[idx];
    assign cm_tag_out[TAG_W*s +: TAG_W]    = idx;
  end

  // ---------------- dispatch / write-back ----------------
  // ready depends on registered state only; a same-cycle commit does not
  // free a slot for dispatch
  assign disp_ready_out = rst_n_in & rdy_in & (count_q < CNT_FULL) & ~flush_out;
  assign disp_fire      = disp_valid_in & disp_ready_out;
  assign disp_tag_out   = tail_q;
  assign count_out      = count_q;

  assign wb0_hit = wb0_valid_in & vld_q[wb0_tag_in];
  assign wb1_hit = wb1_valid_in & vld_q[wb1_tag_in];

  always_comb begin
    vld_d  = vld_q;
    done_d = done_q;
    if (wb0_hit) done_d[wb0_tag_in] = 1'b1;
    if (wb1_hit) done_d[wb1_tag_in] = 1'b1;
    if (ret[0])  vld_d[h0] = 1'b0;
    if (ret[1])  vld_d[h1] = 1'b0;
    // tail slot is never valid when dispatch is allowed, so this cannot
    // collide with a retire or a write-back hit
    if (disp_fire) begin
      vld_d[tail_q]  = 1'b1;
      done_d[tail_q] = disp_done_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_q   <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      if (flush_out) begin
        vld_q   <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        vld_q   <= vld_d;
        done_q  <= done_d;
        head_q  <= head_q + TAG_W'(n_ret);
        tail_q  <= tail_q + TAG_W'(disp_fire);
        count_q <= count_q + (TAG_W+1)'(disp_fire) - (TAG_W+1)'(n_ret);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush_out) begin
      if (wb0_hit) begin
        value_q[wb0_tag_in] <= wb0_value_in;
        if (type_q[wb0_tag_in] == T_BRANCH) taken_q[wb0_tag_in] <= wb0_taken_in;
        if (type_q[wb0_tag_in] == T_JALR)   pc_q[wb0_tag_in]    <= wb0_target_in;
      end
      // wb1 after wb0 so it wins on a (disallowed) same-tag collision
      if (wb1_hit) value_q[wb1_tag_in] <= wb1_value_in;
      if (disp_fire) begin
        type_q[tail_q]  <= disp_type_in;
        rd_q[tail_q]    <= disp_rd_in;
        value_q[tail_q] <= disp_value_in;
        pc_q[tail_q]    <= disp_alt_pc_in;
        pred_q[tail_q]  <= disp_pred_taken_in;
        taken_q[tail_q] <= 1'b0;
      end
    end
  end

  // ---------------- operand lookup ----------------
  function automatic logic [32:0] lookup(input logic [TAG_W-1:0] t);
    logic        r;
    logic [31:0] v;
    r = vld_q[t] & done_q[t];
    v = value_q[t];
`ifdef ROB_CDB_BYPASS_EN
    if (wb1_valid_in && (wb1_tag_in == t)) begin
      r = 1'b1;
      v = wb1_value_in;
    end else if (wb0_valid_in && (wb0_tag_in == t)) begin
      r = 1'b1;
      v = wb0_value_in;
    end
`endif
    return {r & rst_n_in, v};
  endfunction

  assign {rd0_ready_out, rd0_value_out} = lookup(rd0_tag_in);
  assign {rd1_ready_out, rd1_value_out} = lookup(rd1_tag_in);

endmodule

// File: tb/tb_rob_multi_commit.sv
// Randomized bench for rob_multi_commit against an in-order queue model.
module tb_rob_multi_commit;
  localparam int DEPTH = 32;
  localparam int TAG_W = 5;
  localparam int CW    = 2;
  localparam int ALU = 0, LD = 1, ST = 2, BR = 3, JR = 4;

  logic                   clk_in = 1'b0;
  logic                   rst_n_in, rdy_in;
  logic                   disp_valid_in, disp_ready_out;
  logic [2:0]             disp_type_in;
  logic [4:0]             disp_rd_in;
  logic [31:0]            disp_alt_pc_in, disp_value_in;
  logic                   disp_pred_taken_in, disp_done_in;
  logic [TAG_W-1:0]       disp_tag_out;
  logic [TAG_W-1:0]       rd0_tag_in, rd1_tag_in;
  logic                   rd0_ready_out, rd1_ready_out;
  logic [31:0]            rd0_value_out, rd1_value_out;
  logic                   wb0_valid_in, wb0_taken_in, wb1_valid_in;
  logic [TAG_W-1:0]       wb0_tag_in, wb1_tag_in;
  logic [31:0]            wb0_value_in, wb0_target_in, wb1_value_in;
  logic [CW-1:0]          cm_valid_out;
  logic [5*CW-1:0]        cm_rd_out;
  logic [32*CW-1:0]       cm_value_out;
  logic [TAG_W*CW-1:0]    cm_tag_out;
  logic                   st_commit_req_out, st_commit_ack_in;
  logic                   flush_out;
  logic [31:0]            flush_pc_out;
  logic [TAG_W:0]         count_out;

  always #5 clk_in = ~clk_in;

  rob_multi_commit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .COMMIT_W(CW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .disp_valid_in(disp_valid_in), .disp_ready_out(disp_ready_out),
    .disp_type_in(disp_type_in), .disp_rd_in(disp_rd_in),
    .disp_alt_pc_in(disp_alt_pc_in), .disp_pred_taken_in(disp_pred_taken_in),
    .disp_done_in(disp_done_in), .disp_value_in(disp_value_in),
    .disp_tag_out(disp_tag_out),
    .rd0_tag_in(rd0_tag_in), .rd1_tag_in(rd1_tag_in),
    .rd0_ready_out(rd0_ready_out), .rd1_ready_out(rd1_ready_out),
    .rd0_value_out(rd0_value_out), .rd1_value_out(rd1_value_out),
    .wb0_valid_in(wb0_valid_in), .wb0_tag_in(wb0_tag_in), .wb0_value_in(wb0_value_in),
    .wb0_taken_in(wb0_taken_in), .wb0_target_in(wb0_target_in),
    .wb1_valid_in(wb1_valid_in), .wb1_tag_in(wb1_tag_in), .wb1_value_in(wb1_value_in),
    .cm_valid_out(cm_valid_out), .cm_rd_out(cm_rd_out), .cm_value_out(cm_value_out),
    .cm_tag_out(cm_tag_out),
    .st_commit_req_out(st_commit_req_out), .st_commit_ack_in(st_commit_ack_in),
    .flush_out(flush_out), .flush_pc_out(flush_pc_out), .count_out(count_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---- reference model: program-order list of in-flight instructions ----
  typedef struct {
    int          tag;
    int          typ;
    logic [4:0]  rd;
    bit          done;
    logic [31:0] val;
    logic [31:0] alt;
    logic [31:0] tgt;
    bit          pred;
    bit          taken;
  } ent_t;

  ent_t rob[$];
  int   tail_m = 0;

  function automatic int find(input int t);
    foreach (rob[i]) if (rob[i].tag == t) return i;
    return -1;
  endfunction

  function automatic bit simple(input int typ);
    return (typ == ALU) || (typ == LD);
  endfunction

  function automatic void look(input int t, output bit r, output logic [31:0] v);
    int i;
    i = find(t);
    r = 0;
    v = '0;
    if (i >= 0 && rob[i].done) begin r = 1; v = rob[i].val; end
`ifdef ROB_CDB_BYPASS_EN
    if (rst_n_in) begin
      if (wb1_valid_in && int'(wb1_tag_in) == t) begin r = 1; v = wb1_value_in; end
      else if (wb0_valid_in && int'(wb0_tag_in) == t) begin r = 1; v = wb0_value_in; end
    end
`endif
  endfunction

  task automatic idle();
    rdy_in = 1; disp_valid_in = 0; disp_type_in = 0; disp_rd_in = 0;
    disp_alt_pc_in = 0; disp_pred_taken_in = 0; disp_done_in = 0; disp_value_in = 0;
    rd0_tag_in = 0; rd1_tag_in = 0;
    wb0_valid_in = 0; wb0_tag_in = 0; wb0_value_in = 0; wb0_taken_in = 0; wb0_target_in = 0;
    wb1_valid_in = 0; wb1_tag_in = 0; wb1_value_in = 0; st_commit_ack_in = 0;
  endtask

  // Called just after a negedge with stimulus applied: check outputs,
  // cross the posedge, advance the model.
  task automatic step();
    int          n, i;
    bit          ok0, r0, r1, fl, sreq, rdyo, lr;
    logic [31:0] lv;
    ent_t        e;
    #1;
    n = rob.size();
    ok0 = 0; sreq = 0; fl = 0; r0 = 0; r1 = 0;
    if (rdy_in && n > 0) begin
      ok0  = rob[0].done;
      sreq = ok0 && rob[0].typ == ST;
      fl   = ok0 && ((rob[0].typ == BR && rob[0].taken != rob[0].pred) || rob[0].typ == JR);
      r0   = ok0 && (rob[0].typ != ST || st_commit_ack_in);
      if (r0 && n > 1) r1 = simple(rob[0].typ) && rob[1].done && simple(rob[1].typ);
    end
    rdyo = rst_n_in && rdy_in && n < DEPTH && !fl;
    chk("disp_ready", disp_ready_out, rdyo);
    chk("disp_tag", disp_tag_out, tail_m);
    chk("count", count_out, n);
    chk("cm_valid", cm_valid_out, {r1, r0});
    chk("flush", flush_out, fl);
    chk("st_req", st_commit_req_out, sreq);
    if (fl) chk("flush_pc", flush_pc_out, rob[0].typ == JR ? rob[0].tgt : rob[0].alt);
    if (r0) begin
      chk("cm0_rd", cm_rd_out[4:0], rob[0].rd);
      chk("cm0_val", cm_value_out[31:0], rob[0].val);
      chk("cm0_tag", cm_tag_out[TAG_W-1:0], rob[0].tag);
    end
    if (r1) begin
      chk("cm1_rd", cm_rd_out[9:5], rob[1].rd);
      chk("cm1_val", cm_value_out[63:32], rob[1].val);
      chk("cm1_tag", cm_tag_out[2*TAG_W-1:TAG_W], rob[1].tag);
    end
    look(rd0_tag_in, lr, lv);
    chk("rd0_ready", rd0_ready_out, lr);
    if (lr) chk("rd0_value", rd0_value_out, lv);
    look(rd1_tag_in, lr, lv);
    chk("rd1_ready", rd1_ready_out, lr);
    if (lr) chk("rd1_value", rd1_value_out, lv);

    @(posedge clk_in);
    if (rdy_in && rst_n_in) begin
      if (fl) begin
        rob.delete();
        tail_m = 0;
      end else begin
        if (r0) void'(rob.pop_front());
        if (r1) void'(rob.pop_front());
        if (wb0_valid_in) begin
          i = find(wb0_tag_in);
          if (i >= 0) begin
            rob[i].done = 1;
            rob[i].val  = wb0_value_in;
            if (rob[i].typ == BR) rob[i].taken = wb0_taken_in;
            if (rob[i].typ == JR) rob[i].tgt   = wb0_target_in;
          end
        end
        if (wb1_valid_in) begin
          i = find(wb1_tag_in);
          if (i >= 0) begin rob[i].done = 1; rob[i].val = wb1_value_in; end
        end
        if (disp_valid_in && rdyo) begin
          e.tag = tail_m; e.typ = int'(disp_type_in); e.rd = disp_rd_in;
          e.done = disp_done_in; e.val = disp_value_in; e.alt = disp_alt_pc_in;
          e.tgt = '0; e.pred = disp_pred_taken_in; e.taken = 0;
          rob.push_back(e);
          tail_m = (tail_m + 1) % DEPTH;
        end
      end
    end
    @(negedge clk_in);
  endtask

  // mode 0: fill with unresolved ALU/LOAD; mode 1: mixed traffic
  task automatic gen(input int mode);
    int pend[$], pls[$];
    int r, k;
    rdy_in = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 90);
    disp_valid_in = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 60);
    r = $urandom_range(0, 99);
    if (mode == 0) disp_type_in = (r < 70) ? 3'(ALU) : 3'(LD);
    else disp_type_in = (r < 40) ? 3'(ALU) : (r < 60) ? 3'(LD) : (r < 75) ? 3'(ST) :
                        (r < 92) ? 3'(BR) : 3'(JR);
    disp_done_in = (mode != 0) && (disp_type_in <= 3'(ST)) && ($urandom_range(0, 3) == 0);
    disp_rd_in = 5'($urandom);
    disp_alt_pc_in = $urandom;
    disp_pred_taken_in = 1'($urandom);
    disp_value_in = $urandom;
    wb0_valid_in = 0; wb1_valid_in = 0;
    wb0_value_in = $urandom; wb0_target_in = $urandom; wb0_taken_in = 1'($urandom);
    wb1_value_in = $urandom;
    foreach (rob[i]) if (!rob[i].done) pend.push_back(i);
    if (mode != 0) begin
      r = $urandom_range(0, 99);
      if (pend.size() > 0 && r < 60) begin
        k = pend[$urandom_range(0, pend.size() - 1)];
        wb0_valid_in = 1;
        wb0_tag_in = TAG_W'(rob[k].tag);
      end else if (r < 66 && rob.size() < DEPTH) begin
        // the tail slot is empty, so this write-back must be ignored
        wb0_valid_in = 1;
        wb0_tag_in = TAG_W'(tail_m);
      end
      foreach (pend[j])
        if ((rob[pend[j]].typ == LD || rob[pend[j]].typ == ST) &&
            !(wb0_valid_in && int'(wb0_tag_in) == rob[pend[j]].tag))
          pls.push_back(pend[j]);
      if (pls.size() > 0 && $urandom_range(0, 99) < 50) begin
        k = pls[$urandom_range(0, pls.size() - 1)];
        wb1_valid_in = 1;
        wb1_tag_in = TAG_W'(rob[k].tag);
      end
    end
    st_commit_ack_in = 1'($urandom);
    rd0_tag_in = (wb0_valid_in && $urandom_range(0, 99) < 40) ? wb0_tag_in : TAG_W'($urandom);
    rd1_tag_in = (wb1_valid_in && $urandom_range(0, 99) < 40) ? wb1_tag_in : TAG_W'($urandom);
  endtask

  task automatic reset_checks(input string pfx);
    chk({pfx, "_disp_ready"}, disp_ready_out, 0);
    chk({pfx, "_disp_tag"}, disp_tag_out, 0);
    chk({pfx, "_cm_valid"}, cm_valid_out, 0);
    chk({pfx, "_flush"}, flush_out, 0);
    chk({pfx, "_st_req"}, st_commit_req_out, 0);
    chk({pfx, "_rd0_ready"}, rd0_ready_out, 0);
    chk({pfx, "_rd1_ready"}, rd1_ready_out, 0);
    chk({pfx, "_count"}, count_out, 0);
  endtask

  initial begin
    idle();
    rdy_in = 0;
    rst_n_in = 0;
    #1;
    reset_checks("por");
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1;

    // two dispatches-worth of pairing: rd 1/2/3, then out-of-order write-back
    for (int i = 1; i <= 3; i++) begin
      idle(); disp_valid_in = 1; disp_rd_in = 5'(i); disp_value_in = 32'(i);
      step();
    end
    idle();
    wb0_valid_in = 1; wb0_tag_in = 1; wb0_value_in = 32'h11;
    wb1_valid_in = 1; wb1_tag_in = 0; wb1_value_in = 32'h22;
    step();
    idle();
    #1;
    chk("pair_cm_valid", cm_valid_out, 2'b11);
    chk("pair_values", cm_value_out, {32'h11, 32'h22});
    step();
    idle();
    #1;
    chk("pair_count_after", count_out, 1);
    step();

    // fill to full, then reset asynchronously with entries in flight
    for (int c = 0; c < 40; c++) begin gen(0); step(); end
    idle();
    rst_n_in = 0;
    #1;
    reset_checks("async");
    rob.delete();
    tail_m = 0;
    @(posedge clk_in);
    @(negedge clk_in);
    reset_checks("held");
    rst_n_in = 1;

    for (int c = 0; c < 40; c++) begin gen(0); step(); end
    for (int c = 0; c < 3000; c++) begin gen(1); step(); end
    for (int c = 0; c < 40; c++) begin gen(0); step(); end
    for (int c = 0; c < 1500; c++) begin gen(1); step(); end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
